// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states and
// default latencies.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    StIdle,
    StRun
  } md_state_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_if.sv
// Request/result bundle between EX and the multiply/divide unit.
// The flush signal exists only when MDU_FLUSH_EN is defined.
interface md_if;

  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
`ifdef MDU_FLUSH_EN
  logic        flush;
`endif
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b,
`ifdef MDU_FLUSH_EN
    output flush,
`endif
    input  busy, hi, lo
  );

  modport slave (
    input  start, op, a, b,
`ifdef MDU_FLUSH_EN
    input  flush,
`endif
    output busy, hi, lo
  );

endinterface

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath producing the 64-bit {hi, lo} result,
// including the divide-by-zero and signed-overflow results.
module md_calc
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res
);

  logic        sgn;
  logic        is_div;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] divisor;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q;
  logic [31:0] r;

  always_comb begin
    sgn    = (op == MD_MULT) || (op == MD_DIV);
    is_div = (op == MD_DIV) || (op == MD_DIVU);

    a_ext = {{32{sgn & a[31]}}, a};
    b_ext = {{32{sgn & b[31]}}, b};
    prod  = a_ext * b_ext;

    // Sign-magnitude divide: 0x8000_0000 / -1 falls out as 0x8000_0000 rem 0.
    a_mag   = (sgn && a[31]) ? (~a + 32'd1) : a;
    b_mag   = (sgn && b[31]) ? (~b + 32'd1) : b;
    divisor = (b == 32'd0) ? 32'd1 : b_mag;
    q_mag   = a_mag / divisor;
    r_mag   = a_mag % divisor;
    q       = (sgn && (a[31] ^ b[31])) ? (~q_mag + 32'd1) : q_mag;
    r       = (sgn && a[31]) ? (~r_mag + 32'd1) : r_mag;

    if (!is_div) begin
      res = prod;
    end else if (b == 32'd0) begin
      res = {a, 32'hFFFF_FFFF};
    end else begin
      res = {r, q};
    end
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; busy models the fixed latency.
// Optional MDU_FLUSH_EN adds a flush input that cancels the in-flight op.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic clk,
  input logic reset,
  md_if.slave bus
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  md_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [63:0]     pend_q, pend_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  logic [63:0]     calc_res;
  logic            flush;

`ifdef MDU_FLUSH_EN
  assign flush = bus.flush;
`else
  assign flush = 1'b0;
`endif

  md_calc u_calc (
    .op  (bus.op),
    .a   (bus.a),
    .b   (bus.b),
    .res (calc_res)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    if (flush) begin
      // Drops both the in-flight op and any op starting this cycle.
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            case (bus.op)
              MD_MULT, MD_MULTU: begin
                pend_d  = calc_res;
                cnt_d   = CntW'(MULT_CYCLES);
                state_d = StRun;
              end
              MD_DIV, MD_DIVU: begin
                pend_d  = calc_res;
                cnt_d   = CntW'(DIV_CYCLES);
                state_d = StRun;
              end
              MD_MTHI: hi_d = bus.a;
              MD_MTLO: lo_d = bus.a;
              default: ;
            endcase
          end
        end
        StRun: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) begin
            hi_d    = pend_q[63:32];
            lo_d    = pend_q[31:0];
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pend_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy = (state_q == StRun);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit; flush cases run when MDU_FLUSH_EN is defined.
module tb_md_unit;
  import md_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   start_in_run = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  md_if bus ();

  md_unit #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always @(posedge clk) begin
    if (reset && bus.busy && bus.start) start_in_run <= start_in_run + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_md(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int n, input logic [31:0] eh,
                        input logic [31:0] el);
    int cnt = 0;
    issue(o, x, y);
    check({tag, "_hi_hidden"}, {32'd0, bus.hi}, {32'd0, m_hi});
    check({tag, "_lo_hidden"}, {32'd0, bus.lo}, {32'd0, m_lo});
    while (bus.busy && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 64'(cnt), 64'(n));
    check({tag, "_hi"}, {32'd0, bus.hi}, {32'd0, eh});
    check({tag, "_lo"}, {32'd0, bus.lo}, {32'd0, el});
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.a     = '0;
    bus.b     = '0;
`ifdef MDU_FLUSH_EN
    bus.flush = 1'b0;
`endif
    reset = 1'b1;
    #2 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    check("reset_hi", {32'd0, bus.hi}, 64'd0);
    check("reset_lo", {32'd0, bus.lo}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Back-to-back: each op starts on the cycle right after busy falls.
    run_md("mult_neg",  MD_MULT,  32'hFFFF_FFFE, 32'd3,         5,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_md("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'd2,         5,  32'h0000_0001, 32'hFFFF_FFFE);
    run_md("mult_min",  MD_MULT,  32'h8000_0000, 32'h8000_0000, 5,  32'h4000_0000, 32'h0000_0000);
    run_md("div_neg",   MD_DIV,   32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("div_negb",  MD_DIV,   32'd7,         32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
    run_md("divu_zero", MD_DIVU,  32'd100,       32'd0,         10, 32'd100,       32'hFFFF_FFFF);
    run_md("div_zero",  MD_DIV,   32'hFFFF_FFFB, 32'd0,         10, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_md("div_ovf",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
    run_md("divu_big",  MD_DIVU,  32'hFFFF_FFFF, 32'd10,        10, 32'h0000_0005, 32'h1999_9999);

    // mthi then mtlo on consecutive cycles.
    bus.start = 1'b1;
    bus.op    = MD_MTHI;
    bus.a     = 32'h1234;
    @(negedge clk);
    check("mthi_hi", {32'd0, bus.hi}, 64'h1234);
    check("mthi_busy", {63'd0, bus.busy}, 64'd0);
    bus.op = MD_MTLO;
    bus.a  = 32'h5678;
    @(negedge clk);
    bus.start = 1'b0;
    check("mtlo_lo", {32'd0, bus.lo}, 64'h5678);
    check("mtlo_hi", {32'd0, bus.hi}, 64'h1234);
    check("mtlo_busy", {63'd0, bus.busy}, 64'd0);
    m_hi = 32'h1234;
    m_lo = 32'h5678;

    // Reserved ops change nothing.
    for (int i = 6; i < 8; i++) begin
      issue(3'(i), 32'hDEAD_BEEF, 32'd1);
      check("rsvd_busy", {63'd0, bus.busy}, 64'd0);
      check("rsvd_hi", {32'd0, bus.hi}, {32'd0, m_hi});
      check("rsvd_lo", {32'd0, bus.lo}, {32'd0, m_lo});
    end

    // Reset pulsed mid-divide takes effect immediately.
    issue(MD_DIV, 32'd9, 32'd2);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_mid_hi", {32'd0, bus.hi}, 64'd0);
    check("rst_mid_lo", {32'd0, bus.lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    run_md("mult_after_rst", MD_MULT, 32'd6, 32'd7, 5, 32'd0, 32'd42);

`ifdef MDU_FLUSH_EN
    issue(MD_MTHI, 32'hAAAA, 32'd0);
    m_hi = 32'hAAAA;
    issue(MD_DIV, 32'd100, 32'd3);
    repeat (3) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", {63'd0, bus.busy}, 64'd0);
    check("flush_hi", {32'd0, bus.hi}, {32'd0, m_hi});
    check("flush_lo", {32'd0, bus.lo}, {32'd0, m_lo});
    bus.flush = 1'b1;
    issue(MD_MTLO, 32'h9999, 32'd0);
    bus.flush = 1'b0;
    check("flush_mtlo_lo", {32'd0, bus.lo}, {32'd0, m_lo});
    issue(MD_MULT, 32'd3, 32'd3);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    repeat (12) @(negedge clk);
    check("flush_late_busy", {63'd0, bus.busy}, 64'd0);
    check("flush_late_hi", {32'd0, bus.hi}, {32'd0, m_hi});
    check("flush_late_lo", {32'd0, bus.lo}, {32'd0, m_lo});
`endif

    check("no_start_in_run", 64'(start_in_run), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
